// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO-to-DAC SPI path: FSM states, widths, LFSR seed.
// Pure declarations; no timing or flow-control behaviour of its own.
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int SAMPLE_W = 18;
  localparam int DAC_W    = 12;
  localparam int FRAME_W  = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Top 12 bits of the two's complement sample, MSB flipped to give offset binary.
  function automatic logic [DAC_W-1:0] to_code(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-DAC_W]};
  endfunction

endpackage

// File: rtl/nco_sample_fifo.sv
// Sample FIFO, show-ahead read (dout valid same cycle as !empty), one-cycle write latency.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module nco_sample_fifo
  import nco_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nco_sample_spi.sv
// NCO samples -> FIFO -> 16-bit SPI DAC frames; frame period SCLK_DIV*34+1 clk, cs_n low SCLK_DIV*33.
// No backpressure upstream: samples arriving at a full FIFO are dropped and flag sticky overflow. Optional NCO_SPI_DITHER_EN.
module nco_sample_spi
  import nco_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          SCLK_DIV   = 4,
  parameter logic [3:0]  DAC_CMD    = 4'b0011
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi,
  output logic                busy,
  output logic                overflow
);

  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

  logic                          push_req;
  logic                          pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [SAMPLE_W-1:0]           fifo_dout;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_count_unused;
  logic [SAMPLE_W-1:0]           sample_pre;
  logic [FRAME_W-1:0]            frame_load;

  state_t             state, state_n;
  logic [7:0]         div_cnt, div_n;
  logic [3:0]         bit_cnt, bit_n;
  logic               sclk_q, sclk_n;
  logic [FRAME_W-1:0] shreg, sh_n;

  assign push_req          = in_valid && clken;
  assign fifo_count_unused = ^fifo_count;

  nco_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (in_sample),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                overflow <= 1'b0;
    else if (push_req && fifo_full && !pop)   overflow <= 1'b1;
  end

`ifdef NCO_SPI_DITHER_EN
  logic [15:0]         lfsr;
  logic [SAMPLE_W:0]   dsum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    lfsr <= LFSR_SEED;
    else if (pop) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Only a positive sample can overflow when a non-negative dither is added.
  always_comb begin
    dsum       = {fifo_dout[SAMPLE_W-1], fifo_dout} + {13'd0, lfsr[5:0]};
    sample_pre = (!dsum[SAMPLE_W] && dsum[SAMPLE_W-1]) ? 18'h1FFFF : dsum[SAMPLE_W-1:0];
  end
`else
  assign sample_pre = fifo_dout;
`endif

  assign frame_load = {DAC_CMD, to_code(sample_pre)};

  assign busy     = (state != IDLE);
  assign dac_cs_n = !(state == LOAD || state == SHIFT);
  assign dac_sclk = sclk_q;
  assign dac_mosi = (state == LOAD || state == SHIFT) ? shreg[FRAME_W-1] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      sclk_q  <= sclk_n;
      shreg   <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    sclk_n  = sclk_q;
    sh_n    = shreg;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = frame_load;
          div_n   = '0;
          bit_n   = '0;
          sclk_n  = 1'b0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          sclk_n  = 1'b1;
          state_n = SHIFT;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n = '0;
          if (sclk_q) begin
            // Falling edge: next bit onto mosi while the DAC holds off sampling.
            sclk_n = 1'b0;
            sh_n   = {shreg[FRAME_W-2:0], 1'b0};
          end else if (bit_cnt == 4'd15) begin
            state_n = GAP;
          end else begin
            bit_n  = bit_cnt + 1'b1;
            sclk_n = 1'b1;
          end
        end
      end
      GAP: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nco_sample_spi.sv
// Bench for nco_sample_spi (default build): an SPI receiver rebuilds frames from the pins
// and compares them against frames computed arithmetically from the accepted samples.
module tb_nco_sample_spi;

  localparam int         SCLK_DIV = 4;
  localparam logic [3:0] CMD      = 4'b0011;

  logic        clk;
  logic        reset;
  logic        clken;
  logic        in_valid;
  logic [17:0] in_sample;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  nco_sample_spi #(.FIFO_DEPTH(8), .SCLK_DIV(SCLK_DIV), .DAC_CMD(CMD)) dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .dac_cs_n  (dac_cs_n),
    .dac_sclk  (dac_sclk),
    .dac_mosi  (dac_mosi),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: code = floor(sample / 64) + 2048, i.e. offset binary of the top 12 bits.
  function automatic logic [15:0] exp_frame(input logic [17:0] s);
    int v;
    v = $signed(s);
    v = (v >>> 6) + 2048;
    return {CMD, 12'(v)};
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          gotbits_q[$];
  int          gotlow_q[$];

  logic [15:0] m_sh   = '0;
  int          m_bits = 0;
  int          m_low  = 0;
  int          viol   = 0;
  logic        p_cs   = 1'b1;
  logic        p_sclk = 1'b0;
  logic        p_mosi = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      m_sh = '0; m_bits = 0; m_low = 0;
    end else if (!dac_cs_n) begin
      m_low++;
      if (dac_sclk && !p_sclk) begin
        m_sh = {m_sh[14:0], dac_mosi};
        m_bits++;
      end
      if (!p_cs && (dac_mosi !== p_mosi) && !(p_sclk && !dac_sclk)) viol++;
    end else if (!p_cs) begin
      got_q.push_back(m_sh);
      gotbits_q.push_back(m_bits);
      gotlow_q.push_back(m_low);
      m_sh = '0; m_bits = 0; m_low = 0;
    end
    p_cs   = reset ? 1'b1 : dac_cs_n;
    p_sclk = dac_sclk;
    p_mosi = dac_mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ce, input logic [17:0] s);
    in_valid  = v;
    clken     = ce;
    in_sample = s;
    if (v && ce) exp_q.push_back(exp_frame(s));
    @(posedge clk); #1;
    in_valid = 1'b0;
    clken    = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    int t;
    n = exp_q.size();
    t = 0;
    while (got_q.size() < n && t < budget) begin
      @(posedge clk); t++;
    end
    repeat (160) @(posedge clk);
    #1;
    check({tag, "_nframes"}, got_q.size(), n);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({tag, "_frame"}, got_q.pop_front(), exp_q.pop_front());
      check({tag, "_bits"}, gotbits_q.pop_front(), 16);
      check({tag, "_cs_low"}, gotlow_q.pop_front(), SCLK_DIV * 33);
    end
    exp_q.delete(); got_q.delete(); gotbits_q.delete(); gotlow_q.delete();
  endtask

  initial begin
    int t;
    reset = 1'b1; clken = 1'b0; in_valid = 1'b0; in_sample = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", dac_cs_n, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_mosi", dac_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", dut.u_fifo.count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    drive(1'b1, 1'b1, 18'h1FFFF);
    check("model_max", exp_q[0], 16'h3FFF);
    drain("max", 400);
    drive(1'b1, 1'b1, 18'h20000);
    drain("min", 400);
    drive(1'b1, 1'b1, 18'h00000);
    drain("zero", 400);

    for (int b = 0; b < 6; b++) begin
      int k;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++)
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 18'($urandom));
      drain("rand", 8 * 200);
    end

    drive(1'b1, 1'b0, 18'h15555);
    repeat (3) @(posedge clk);
    #1;
    check("noclken_count", dut.u_fifo.count, 0);
    check("noclken_busy", busy, 0);
    drain("noclken", 10);
    check("pre_burst_overflow", overflow, 0);

    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 18'($urandom));
    // One pop in the second cycle leaves room for nine; the tenth finds the FIFO full.
    void'(exp_q.pop_back());
    check("burst_overflow", overflow, 1);
    drain("burst10", 9 * 200);
    check("overflow_sticky", overflow, 1);
    check("burst_count", dut.u_fifo.count, 0);

    drive(1'b1, 1'b1, 18'h0ABCD);
    exp_q.delete();
    t = 0;
    while (m_bits < 8 && t < 2000) begin
      @(negedge clk); #1; t++;
    end
    check("midframe_bits", m_bits, 8);
    #1 reset = 1'b1;
    #1;
    check("midrst_cs_n", dac_cs_n, 1);
    check("midrst_sclk", dac_sclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("post_rst_frames", got_q.size(), 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_count", dut.u_fifo.count, 0);
    check("mosi_edge_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_sample_spi.md
NCO_SAMPLE_SPI -- requirements
Module: nco_sample_spi

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: sample buffer depth; power of two, 2..64.
REQ-002 SHALL have parameter SCLK_DIV, default 4: clk cycles per dac_sclk half-period; 1..255.
REQ-003 SHALL have parameter DAC_CMD, default 4'b0011: 4-bit command prefix of every frame.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port clken, input, 1: input qualifier, same clock enable as the NCO.
REQ-007 SHALL have port in_valid, input, 1: NCO out_valid.
REQ-008 SHALL have port in_sample, input, 18: NCO fsin_o, two's complement.
REQ-009 SHALL have port dac_cs_n, output, 1: DAC chip select, active low.
REQ-010 SHALL have port dac_sclk, output, 1: DAC serial clock.
REQ-011 SHALL have port dac_mosi, output, 1: DAC serial data, MSB first.
REQ-012 SHALL have port busy, output, 1: high while the FSM is not in IDLE.
REQ-013 SHALL have port overflow, output, 1: sticky flag for a dropped sample.

Function
REQ-014 SHALL push in_sample into the FIFO in each cycle where in_valid and clken are both 1.
REQ-015 SHALL drop the sample and set overflow when a push hits a full FIFO and no pop occurs in the same cycle.
REQ-016 SHALL accept a push to a full FIFO when a pop occurs in the same cycle.
REQ-017 SHALL convert each sample to 12 bits by taking in_sample[17:6] and inverting bit 11 (offset binary), with no rounding.
REQ-018 SHALL form each frame as {DAC_CMD, code[11:0]}, 16 bits, sent MSB first.
REQ-019 SHALL use FSM states IDLE, LOAD, SHIFT and GAP.
REQ-020 IDLE SHALL pop the FIFO when it is non-empty, latch the frame and go to LOAD on the next cycle.
REQ-021 LOAD SHALL drive dac_cs_n low and dac_mosi to frame bit 15 for SCLK_DIV cycles with dac_sclk low, then go to SHIFT.
REQ-022 In SHIFT, each bit SHALL drive dac_sclk high for SCLK_DIV cycles and then low for SCLK_DIV cycles.
REQ-023 In SHIFT, dac_mosi SHALL change only on the dac_sclk falling edge.
REQ-024 After 16 bits, SHIFT SHALL go to GAP.
REQ-025 GAP SHALL hold dac_cs_n high and dac_sclk low for SCLK_DIV cycles, then return to IDLE.
REQ-026 dac_cs_n SHALL stay low for exactly SCLK_DIV*33 cycles per frame.
REQ-027 The FIFO SHALL continue to accept pushes during LOAD, SHIFT and GAP.
REQ-028 The FSM SHALL pop only in IDLE.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 The FIFO occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-031 When reset is asserted, all state SHALL clear at once, including in the middle of a frame.
REQ-032 On reset, dac_cs_n SHALL be 1, dac_sclk 0, dac_mosi 0, busy 0 and overflow 0.
REQ-033 On reset, the FIFO SHALL be empty and the FSM SHALL be in IDLE.
REQ-034 overflow SHALL clear only on reset.

Configuration
REQ-035 When NCO_SPI_DITHER_EN is defined, the block SHALL add a 6-bit value from a 16-bit maximal LFSR to in_sample before truncation.
REQ-036 Under NCO_SPI_DITHER_EN, the LFSR SHALL advance once per pop, with seed 16'hACE1 after reset.
REQ-037 Under NCO_SPI_DITHER_EN, the dithered sum SHALL saturate at 18'h1FFFF.
REQ-038 When NCO_SPI_DITHER_EN is undefined, the block SHALL apply plain truncation and SHALL contain no LFSR logic.

Structure
REQ-039 Package nco_pkg SHALL hold the FSM state enum, the SAMPLE_W=18, DAC_W=12 and FRAME_W=16 constants, and the LFSR seed.
REQ-040 The FIFO SHALL be the sub-module nco_sample_fifo, with ports push, pop, din, dout, full, empty and count.

Verification
REQ-041 in_sample 18'h1FFFF with SCLK_DIV=4 SHALL produce frame 16'h3FFF and dac_cs_n low for 132 cycles.
REQ-042 in_sample 18'h20000 SHALL produce frame 16'h3000; in_sample 0 SHALL produce frame 16'h3800.
REQ-043 Ten consecutive valid samples from idle SHALL produce nine frames in order, drop the tenth sample, and set overflow to 1.
REQ-044 A sample offered with clken=0 and in_valid=1 SHALL produce no frame and leave the FIFO count at 0.
REQ-045 Asserting reset at SHIFT bit 7 SHALL set dac_cs_n=1 and dac_sclk=0 immediately, and no frame SHALL follow without new input.
REQ-046 With NCO_SPI_DITHER_EN defined, in_sample 18'h1FFFF SHALL saturate and still produce frame 16'h3FFF.
